// File: rtl/motor_pkg.sv
// Shared types, constants and helpers for the motor command sequencer.
package motor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DEAD
   } chan_state_t;

   // Number of pwm_cnt steps per PWM period (pwm_cnt counts 0..PWM_PERIOD-1).
   localparam int unsigned PWM_PERIOD = 127;

   // Magnitude of a signed speed command; -128 saturates to 127.
   function automatic logic [6:0] cmd_mag(input logic signed [7:0] cmd);
      if (cmd == 8'sh80) begin
         return 7'd127;
      end
      return cmd[7] ? 7'(-cmd) : cmd[6:0];
   endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: pending/duty registers, IDLE/DRIVE/DEAD sequencing
// with dead time on reversal, and registered enable/direction outputs.
module motor_channel
   import motor_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 50
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_valid,
   input  logic signed [7:0] cmd,
   input  logic              abort,
   input  logic [6:0]        pwm_cnt_next,
   input  logic              pwm_wrap,
   output logic              enable,
   output logic              dir_fwd,
   output logic              dir_rev
);

   localparam int unsigned   DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

   chan_state_t       state;
   logic signed [7:0] pending;
   logic [6:0]        duty;
   logic [6:0]        pend_mag;
   logic [DW-1:0]     dead_cnt;
   logic              pend_zero;
   logic              pend_rev;

   // Decode the pending command into magnitude, zero and direction flags.
   always_comb begin
      pend_mag  = cmd_mag(pending);
      pend_zero = (pending == 8'sd0);
      pend_rev  = pending[7];
   end

   // Enable is registered from the next-cycle pwm count and duty, so the
   // flop equals (state == DRIVE) && (pwm_cnt < duty) every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         pending  <= '0;
         duty     <= '0;
         dead_cnt <= '0;
         enable   <= 1'b0;
         dir_fwd  <= 1'b0;
         dir_rev  <= 1'b0;
      end else begin
         if (frame_valid) begin
            pending <= cmd;
         end else if (abort) begin
            pending <= '0;
         end

         if (abort) begin
            state    <= IDLE;
            duty     <= '0;
            dead_cnt <= '0;
            enable   <= 1'b0;
            dir_fwd  <= 1'b0;
            dir_rev  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  enable <= 1'b0;
                  if (!pend_zero) begin
                     state   <= DRIVE;
                     duty    <= pend_mag;
                     dir_fwd <= !pend_rev;
                     dir_rev <= pend_rev;
                     enable  <= (pwm_cnt_next < pend_mag);
                  end
               end
               DRIVE: begin
                  if (pend_zero) begin
                     state   <= IDLE;
                     enable  <= 1'b0;
                     dir_fwd <= 1'b0;
                     dir_rev <= 1'b0;
                  end else if (pend_rev != dir_rev) begin
                     state    <= DEAD;
                     dead_cnt <= '0;
                     enable   <= 1'b0;
                     dir_fwd  <= 1'b0;
                     dir_rev  <= 1'b0;
                  end else if (pwm_wrap) begin
                     duty   <= pend_mag;
                     enable <= (pwm_cnt_next < pend_mag);
                  end else begin
                     enable <= (pwm_cnt_next < duty);
                  end
               end
               DEAD: begin
                  enable <= 1'b0;
                  if (dead_cnt == DEAD_LAST) begin
                     if (pend_zero) begin
                        state <= IDLE;
                     end else begin
                        state   <= DRIVE;
                        duty    <= pend_mag;
                        dir_fwd <= !pend_rev;
                        dir_rev <= pend_rev;
                        enable  <= (pwm_cnt_next < pend_mag);
                     end
                  end else begin
                     dead_cnt <= dead_cnt + 1'b1;
                  end
               end
               default: begin
                  state   <= IDLE;
                  enable  <= 1'b0;
                  dir_fwd <= 1'b0;
                  dir_rev <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Two-channel motor command sequencer: shared PWM prescaler/counter and
// frame watchdog feeding two motor_channel instances.
module motor_cmd_sequencer
   import motor_pkg::*;
#(
   parameter int unsigned PWM_DIV     = 4,
   parameter int unsigned DEAD_CYCLES = 50,
   parameter int unsigned WDOG_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_valid,
   input  logic signed [7:0] motor1,
   input  logic signed [7:0] motor2,
   output logic              enable12,
   output logic              enable34,
   output logic              a1,
   output logic              a2,
   output logic              a3,
   output logic              a4,
   output logic              wdog_fault
);

   localparam int unsigned   PW         = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int unsigned   WW         = $clog2(WDOG_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);
   localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);
   localparam logic [6:0]    PWM_LAST   = 7'(PWM_PERIOD - 1);

   logic [PW-1:0] presc;
   logic [6:0]    pwm_cnt;
   logic [6:0]    pwm_cnt_next;
   logic          pwm_tick;
   logic          pwm_wrap;
   logic [WW-1:0] wdog_cnt;
   logic          timeout;

   // PWM tick/wrap decode and watchdog expiry (a frame on the same cycle wins).
   always_comb begin
      pwm_tick     = (presc == PRESC_LAST);
      pwm_wrap     = pwm_tick && (pwm_cnt == PWM_LAST);
      pwm_cnt_next = pwm_cnt;
      if (pwm_wrap) begin
         pwm_cnt_next = '0;
      end else if (pwm_tick) begin
         pwm_cnt_next = pwm_cnt + 1'b1;
      end
      timeout = !frame_valid && !wdog_fault && (wdog_cnt == WDOG_LAST);
   end

   // Shared prescaler and 0..126 PWM counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else begin
         presc   <= pwm_tick ? '0 : presc + 1'b1;
         pwm_cnt <= pwm_cnt_next;
      end
   end

   // Frame watchdog: cleared by each frame, holds once the fault latches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_cnt   <= '0;
         wdog_fault <= 1'b0;
      end else if (frame_valid) begin
         wdog_cnt   <= '0;
         wdog_fault <= 1'b0;
      end else if (timeout) begin
         wdog_fault <= 1'b1;
      end else if (!wdog_fault) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end

   motor_channel #(
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_ch1 (
      .clk          (clk),
      .reset        (reset),
      .frame_valid  (frame_valid),
      .cmd          (motor1),
      .abort        (timeout),
      .pwm_cnt_next (pwm_cnt_next),
      .pwm_wrap     (pwm_wrap),
      .enable       (enable12),
      .dir_fwd      (a1),
      .dir_rev      (a2)
   );

   motor_channel #(
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_ch2 (
      .clk          (clk),
      .reset        (reset),
      .frame_valid  (frame_valid),
      .cmd          (motor2),
      .abort        (timeout),
      .pwm_cnt_next (pwm_cnt_next),
      .pwm_wrap     (pwm_wrap),
      .enable       (enable34),
      .dir_fwd      (a3),
      .dir_rev      (a4)
   );

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Self-checking bench for motor_cmd_sequencer: table of steady-state frames,
// hand-written corner sequences, and randomized frames against a
// cycle-count based reference model.
module tb_motor_cmd_sequencer;

   localparam int unsigned PWM_DIV = 1;
   localparam int unsigned DEAD    = 4;
   localparam int unsigned WDOG    = 1000;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_valid;
   logic signed [7:0] motor1;
   logic signed [7:0] motor2;
   logic              enable12, enable34, a1, a2, a3, a4, wdog_fault;
   logic [6:0]        outs;

   motor_cmd_sequencer #(
      .PWM_DIV     (PWM_DIV),
      .DEAD_CYCLES (DEAD),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .motor1      (motor1),
      .motor2      (motor2),
      .enable12    (enable12),
      .enable34    (enable34),
      .a1          (a1),
      .a2          (a2),
      .a3          (a3),
      .a4          (a4),
      .wdog_fault  (wdog_fault)
   );

   assign outs = {enable12, enable34, a1, a2, a3, a4, wdog_fault};

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: time in edges since reset, direction -1/0/+1,
   // remaining dead cycles, duty, pending command.
   int m_n, m_last;
   bit m_fault;
   int m_pend[2], m_dir[2], m_rem[2], m_duty[2];

   typedef struct {
      logic signed [7:0] m1;
      logic signed [7:0] m2;
      logic [1:0]        d12;
      logic [1:0]        d34;
      int                on12;
      int                on34;
   } vec_t;

   vec_t tbl[6];

   function automatic int mag(int c);
      if (c == -128) return 127;
      return (c < 0) ? -c : c;
   endfunction

   function automatic int sgn(int c);
      return (c < 0) ? -1 : 1;
   endfunction

   task automatic model_reset();
      m_n = 0; m_last = 0; m_fault = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_pend[i] = 0; m_dir[i] = 0; m_rem[i] = 0; m_duty[i] = 0;
      end
   endtask

   task automatic model_edge(bit fv, int c1, int c2);
      int p_before, p_after, p;
      bit wrap, abort;
      p_before = (m_n / int'(PWM_DIV)) % 127;
      m_n++;
      p_after  = (m_n / int'(PWM_DIV)) % 127;
      wrap     = (p_before == 126) && (p_after == 0);
      abort    = 1'b0;
      if (fv) begin
         m_last  = m_n;
         m_fault = 1'b0;
      end else if (!m_fault && (m_n - m_last == int'(WDOG))) begin
         abort   = 1'b1;
         m_fault = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         p = m_pend[i];
         if (abort) begin
            m_dir[i] = 0; m_rem[i] = 0; m_duty[i] = 0;
         end else if (m_rem[i] > 0) begin
            m_rem[i]--;
            if (m_rem[i] == 0 && p != 0) begin
               m_dir[i] = sgn(p); m_duty[i] = mag(p);
            end
         end else if (m_dir[i] != 0) begin
            if (p == 0) m_dir[i] = 0;
            else if (sgn(p) != m_dir[i]) begin
               m_dir[i] = 0; m_rem[i] = int'(DEAD);
            end else if (wrap) m_duty[i] = mag(p);
         end else if (p != 0) begin
            m_dir[i] = sgn(p); m_duty[i] = mag(p);
         end
      end
      if (fv) begin
         m_pend[0] = c1; m_pend[1] = c2;
      end else if (abort) begin
         m_pend[0] = 0; m_pend[1] = 0;
      end
   endtask

   function automatic logic [6:0] model_outs();
      int   p;
      logic e1, e2;
      p  = (m_n / int'(PWM_DIV)) % 127;
      e1 = (m_dir[0] != 0) && (p < m_duty[0]);
      e2 = (m_dir[1] != 0) && (p < m_duty[1]);
      return {e1, e2, m_dir[0] == 1, m_dir[0] == -1, m_dir[1] == 1, m_dir[1] == -1, m_fault};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_n, act, exp_v);
      end
   endtask

   // One clock edge: advance the model with the inputs seen at the edge,
   // then compare every output 1 time unit later.
   task automatic step();
      bit fv;
      int c1, c2;
      @(posedge clk);
      fv = frame_valid;
      c1 = int'(motor1);
      c2 = int'(motor2);
      model_edge(fv, c1, c2);
      #1;
      check("outputs_vs_model", 32'(outs), 32'(model_outs()));
   endtask

   task automatic send_frame(input logic signed [7:0] c1, input logic signed [7:0] c2);
      frame_valid = 1'b1;
      motor1      = c1;
      motor2      = c2;
      step();
      frame_valid = 1'b0;
      motor1      = 8'($urandom);
      motor2      = 8'($urandom);
   endtask

   function automatic logic signed [7:0] rnd_cmd();
      case ($urandom_range(0, 5))
         0:       return 8'sd0;
         1:       return 8'sh80;
         2:       return 8'sd127;
         3:       return 8'sd1;
         4:       return -8'sd1;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int on12, on34, lows;

      tbl[0] = '{8'sd64,   -8'sd1,   2'b10, 2'b01, 64,  1};
      tbl[1] = '{8'sh80,   -8'sd1,   2'b01, 2'b01, 127, 1};
      tbl[2] = '{8'sd127,  8'sd0,    2'b10, 2'b00, 127, 0};
      tbl[3] = '{8'sd0,    8'sd5,    2'b00, 2'b10, 0,   5};
      tbl[4] = '{-8'sd3,   8'sh80,   2'b01, 2'b01, 3,   127};
      tbl[5] = '{8'sd1,    8'sd100,  2'b10, 2'b10, 1,   100};

      reset = 1'b0; frame_valid = 1'b0; motor1 = '0; motor2 = '0;
      @(posedge clk); #1;
      check("reset_outputs", 32'(outs), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();

      // No frames after reset: fault at edge WDOG, outputs still off.
      repeat (WDOG - 1) step();
      check("wdog_before_timeout", 32'(wdog_fault), 32'd0);
      step();
      check("wdog_at_timeout", 32'(wdog_fault), 32'd1);
      check("outs_at_timeout", 32'(outs), 32'h01);

      // First frame: directions appear on the next edge.
      send_frame(8'sd64, -8'sd1);
      check("fault_cleared", 32'(wdog_fault), 32'd0);
      step();
      check("first_edge_dir12", 32'({a1, a2}), 32'h2);
      check("first_edge_dir34", 32'({a3, a4}), 32'h1);

      // Steady-state table: direction and enable duty over one full period.
      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].m1, tbl[i].m2);
         repeat (140) step();
         check("tbl_dir12", 32'({a1, a2}), 32'(tbl[i].d12));
         check("tbl_dir34", 32'({a3, a4}), 32'(tbl[i].d34));
         on12 = 0; on34 = 0;
         for (int k = 0; k < 127; k++) begin
            step();
            on12 += int'(enable12);
            on34 += int'(enable34);
         end
         check("tbl_on12", 32'(on12), 32'(tbl[i].on12));
         check("tbl_on34", 32'(on34), 32'(tbl[i].on34));
      end

      // Reversal forward -> -128: DEAD cycles of 00, then reverse at full duty.
      send_frame(8'sh80, 8'sd100);
      for (int k = 0; k < int'(DEAD); k++) begin
         step();
         check("rev_dead_off", 32'({a1, a2, enable12}), 32'h0);
      end
      step();
      check("rev_new_dir", 32'({a1, a2}), 32'h1);
      check("rev_enable", 32'(enable12), 32'd1);
      lows = 0;
      repeat (130) begin
         step();
         lows += int'(!enable12);
      end
      check("rev_full_duty", 32'(lows), 32'd0);

      // Frame of 0 during DEAD: dead time completes, then stays off.
      send_frame(8'sd50, 8'sd100);
      step();
      send_frame(8'sd0, 8'sd100);
      repeat (10) begin
         step();
         check("dead_then_idle", 32'({a1, a2, enable12}), 32'h0);
      end

      // Watchdog while driving, then recovery by the next frame.
      send_frame(8'sd100, 8'sd0);
      repeat (WDOG - 1) step();
      check("drive_wdog_before", 32'(wdog_fault), 32'd0);
      step();
      check("drive_wdog_fault", 32'(wdog_fault), 32'd1);
      check("drive_wdog_off", 32'({a1, a2, enable12}), 32'h0);
      send_frame(8'sd10, 8'sd0);
      check("recover_fault", 32'(wdog_fault), 32'd0);
      step();
      check("recover_dir", 32'({a1, a2}), 32'h2);

      // Frame on the exact timeout edge suppresses the fault.
      send_frame(8'sd5, 8'sd5);
      repeat (WDOG - 1) step();
      send_frame(8'sd5, 8'sd5);
      check("frame_beats_timeout", 32'(wdog_fault), 32'd0);
      repeat (5) step();

      // Asynchronous reset in the middle of a DEAD interval.
      send_frame(8'sd20, 8'sd127);
      repeat (3) step();
      send_frame(-8'sd20, 8'sd127);
      step();
      step();
      #2 reset = 1'b0;
      #1 check("reset_mid_dead", 32'(outs), 32'd0);
      #1 reset = 1'b1;
      model_reset();

      // Randomized frames, dense then sparse enough to hit the watchdog.
      repeat (4000) begin
         if ($urandom_range(0, 24) == 0) send_frame(rnd_cmd(), rnd_cmd());
         else step();
      end
      repeat (3000) begin
         if ($urandom_range(0, 899) == 0) send_frame(rnd_cmd(), rnd_cmd());
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
